minpool_seq: RTL and testbench
==============================

Name: minpool_seq

Overview:
Sequencer that runs a 3x3, stride-1 min-pool over an IN_DIM x IN_DIM feature map held in a synchronous-read RAM, one pooled pixel at a time. It walks output positions in raster order, issues the nine window reads, folds them into a running minimum, and presents each pooled value on a valid/ready stream. It sits between the feature-map buffer and the downstream pooled-map writer, replacing the fully parallel min-pool array when area matters.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IN_DIM, 8, feature-map side length; output side OUT_DIM = IN_DIM-WIN+1 (6 by default)
WIN, 3, window side length
ADDR_W, 6, RAM address width; must satisfy 2**ADDR_W >= IN_DIM*IN_DIM

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle request to pool the whole map; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE is left
done  out  1  one-cycle pulse after the last pooled pixel is accepted
fm_rd_en  out  1  RAM read strobe
fm_rd_addr  out  ADDR_W  RAM read address, row*IN_DIM+col
fm_rd_data  in  DATA_WIDTH  RAM read data, valid the cycle after fm_rd_en
out_valid  out  1  pooled pixel valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_data  out  DATA_WIDTH  minimum of the current window
out_row  out  3  output row index (0..OUT_DIM-1)
out_col  out  3  output column index (0..OUT_DIM-1)

Behaviour:
- Reset (async, any state): FSM -> IDLE; busy, done, fm_rd_en, out_valid = 0; fm_rd_addr, out_data, out_row, out_col = 0; window and tap counters cleared. An in-flight map is abandoned and no further output is produced.
- States: IDLE, READ, LAST, OUT, DONE.
- IDLE: start=1 -> READ with row=col=0 and tap k=0. start is ignored in all other states.
- READ: fm_rd_en=1, fm_rd_addr=(row+k/WIN)*IN_DIM+(col+k%WIN) for k=0..WIN*WIN-1, one tap per cycle, in row-major order within the window. The cycle after k=0, the accumulator loads fm_rd_data; on later cycles, acc <= min(acc, fm_rd_data). After k=WIN*WIN-1 -> LAST.
- LAST: fm_rd_en=0; fold the final tap; register out_data=min, out_row=row, out_col=col -> OUT.
- OUT: out_valid=1; out_data, out_row and out_col are held stable until the handshake. On out_ready: if row=col=OUT_DIM-1 -> DONE, else advance col (wrap to 0 and increment row) -> READ. out_valid drops the cycle after acceptance.
- DONE: done=1 for one cycle, busy=0 from the next cycle -> IDLE.
- Timing with out_ready held high: 11 cycles per window (9 READ + 1 LAST + 1 OUT). The first out_valid appears 11 cycles after the start edge. A full map is 36*11 cycles, then one DONE cycle.
- Comparison is unsigned by default; ties keep the earlier value (result-identical).
- Backpressure of any length holds state in OUT. No reads are issued while stalled.

Optional Feature:
MINPOOL_SIGNED_EN: when defined, pixel comparison is two's-complement signed, so 0x80 (-128) is the smallest value. When undefined, comparison is unsigned and 0x00 is the smallest value. This is the only difference; ports and timing are identical.

Test Plan:
- All 64 pixels = 0x55, out_ready=1, start pulse -> 36 outputs all 0x55 in raster order (row, col) = (0,0)..(5,5); done pulses once at cycle 36*11+1 after start.
- Ramp pixel[i][j] = i*8+j -> out[r][c] = r*8+c; fm_rd_addr sequence for window (1,2) = 10,11,12,18,19,20,26,27,28.
- Ramp plus pixel[4][4] = 0x00 -> outputs with r,c in {2,3,4} = 0x00; all others equal the ramp value.
- out_ready low for 20 cycles at output (2,3) -> out_valid and out_data stable throughout, fm_rd_en=0 throughout, no output lost or duplicated; 36 outputs in total.
- rst asserted at window (3,1) mid-READ -> all outputs 0 immediately; a new start produces a full 36-pixel run beginning at (0,0). A start pulsed while busy has no effect.
- MINPOOL_SIGNED_EN: pixel[0][0] = 0x80, rest = 0x01 -> out[0][0] = 0x80; without the macro, out[0][0] = 0x01.

Source files
------------

// File: rtl/minpool_seq.sv
// Sequential 3x3 stride-1 min-pool over a feature map held in a sync-read RAM.
// Define MINPOOL_SIGNED_EN for two's-complement pixel comparison (unsigned otherwise).
module minpool_seq #(
   parameter int DATA_WIDTH = 8,
   parameter int IN_DIM     = 8,
   parameter int WIN        = 3,
   parameter int ADDR_W     = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  fm_rd_en,
   output logic [ADDR_W-1:0]     fm_rd_addr,
   input  logic [DATA_WIDTH-1:0] fm_rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [2:0]            out_row,
   output logic [2:0]            out_col
);
   localparam int OUT_DIM = IN_DIM - WIN + 1;
   localparam int KW      = (WIN > 1) ? $clog2(WIN) : 1;
   localparam logic [2:0]    POS_LAST = 3'(OUT_DIM - 1);
   localparam logic [KW-1:0] TAP_LAST = KW'(WIN - 1);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_LAST, S_OUT, S_DONE} state_t;
   state_t state, state_nx;

   logic [2:0]            row, col;
   logic [KW-1:0]         kr, kc;
   logic                  first_q;
   logic [DATA_WIDTH-1:0] acc, fold;
   logic                  last_tap, last_pos;

   function automatic logic less(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
`ifdef MINPOOL_SIGNED_EN
      return $signed(a) < $signed(b);
`else
      return a < b;
`endif
   endfunction

   assign last_tap = (kr == TAP_LAST) && (kc == TAP_LAST);
   assign last_pos = (row == POS_LAST) && (col == POS_LAST);
   // first_q marks the cycle tap 0 returns; strict less keeps the earlier value on ties
   assign fold = first_q ? fm_rd_data : (less(fm_rd_data, acc) ? fm_rd_data : acc);

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign fm_rd_en  = (state == S_READ);
   assign out_valid = (state == S_OUT);

   always_comb begin
      fm_rd_addr = '0;
      if (state == S_READ)
         fm_rd_addr = ADDR_W'((int'(row) + int'(kr)) * IN_DIM + int'(col) + int'(kc));
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (start) state_nx = S_READ;
         S_READ: if (last_tap) state_nx = S_LAST;
         S_LAST: state_nx = S_OUT;
         S_OUT:  if (out_ready) state_nx = last_pos ? S_DONE : S_READ;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         row      <= '0;
         col      <= '0;
         kr       <= '0;
         kc       <= '0;
         first_q  <= 1'b0;
         acc      <= '0;
         out_data <= '0;
         out_row  <= '0;
         out_col  <= '0;
      end else begin
         state   <= state_nx;
         first_q <= (state == S_READ) && (kr == '0) && (kc == '0);
         case (state)
            S_IDLE: if (start) begin
               row <= '0;
               col <= '0;
               kr  <= '0;
               kc  <= '0;
            end
            S_READ: begin
               acc <= fold;
               if (kc == TAP_LAST) begin
                  kc <= '0;
                  kr <= last_tap ? '0 : kr + KW'(1);
               end else begin
                  kc <= kc + KW'(1);
               end
            end
            S_LAST: begin
               acc      <= fold;
               out_data <= fold;
               out_row  <= row;
               out_col  <= col;
            end
            S_OUT: if (out_ready && !last_pos) begin
               if (col == POS_LAST) begin
                  col <= '0;
                  row <= row + 3'd1;
               end else begin
                  col <= col + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_minpool_seq.sv
// Scoreboard bench for minpool_seq: a sync-read RAM model feeds the DUT and a
// reference min-pool fills an expected queue that the output monitor drains.
module tb_minpool_seq;
   logic       clk = 1'b0;
   logic       rst, start, out_ready;
   logic       busy, done, fm_rd_en, out_valid;
   logic [5:0] fm_rd_addr;
   logic [7:0] fm_rd_data, out_data;
   logic [2:0] out_row, out_col;

   minpool_seq dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr), .fm_rd_data(fm_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [64];
   logic [13:0] sb_q[$];
   int vec = 0, err = 0;
   int n_out, busy_cnt, done_cnt, tap, stall_left;
   bit addr_chk, stall_en, stall_seen;
   logic [13:0] held;
   int exp_addr [9] = '{10, 11, 12, 18, 19, 20, 26, 27, 28};

   always @(posedge clk) if (fm_rd_en) fm_rd_data <= mem[fm_rd_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec++;
      if (got !== exp) begin
         err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit lt(input logic [7:0] a, input logic [7:0] b);
`ifdef MINPOOL_SIGNED_EN
      return $signed(a) < $signed(b);
`else
      return a < b;
`endif
   endfunction

   function automatic logic [7:0] win_min(input int r, input int c);
      logic [7:0] m = mem[r*8+c];
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            if (lt(mem[(r+i)*8+c+j], m)) m = mem[(r+i)*8+c+j];
      return m;
   endfunction

   // ready driver: one 20-cycle stall when output (2,3) is presented
   always @(posedge clk) begin
      #1;
      if (stall_en && out_valid && out_row == 3'd2 && out_col == 3'd3 && stall_left > 0) begin
         out_ready = 1'b0;
         stall_left--;
      end else out_ready = 1'b1;
   end

   always @(negedge clk) if (!rst) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (addr_chk && fm_rd_en && n_out == 8 && tap < 9) begin
         chk("addr_w12", fm_rd_addr, exp_addr[tap]);
         tap++;
      end
      if (out_valid && !out_ready) begin
         if (stall_seen) chk("stall_hold", {out_row, out_col, out_data}, held);
         else held = {out_row, out_col, out_data};
         stall_seen = 1'b1;
         chk("stall_rd_en", fm_rd_en, 1'b0);
      end else if (out_valid) begin
         stall_seen = 1'b0;
         if (sb_q.size() == 0) chk("extra_out", 1, 0);
         else chk("pix", {out_row, out_col, out_data}, sb_q.pop_front());
         n_out++;
      end
   end

   task automatic push_expected();
      sb_q.delete();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++)
            sb_q.push_back({3'(r), 3'(c), win_min(r, c)});
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rd_en"}, fm_rd_en, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_addr"}, fm_rd_addr, 0);
      chk({tag, "_outs"}, {out_row, out_col, out_data}, 0);
   endtask

   task automatic run_map(input string tag, input bit pulse_mid, input int stall);
      push_expected();
      n_out = 0; busy_cnt = 0; done_cnt = 0; tap = 0;
      stall_en = (stall > 0); stall_left = stall;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
         @(posedge clk); #1;
         start = pulse_mid && (i == 100);
      end
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_done_once"}, done_cnt, 1);
      chk({tag, "_n_out"}, n_out, 36);
      chk({tag, "_busy_cyc"}, busy_cnt, 36*11 + 1 + stall);
      chk({tag, "_sb_empty"}, sb_q.size(), 0);
      stall_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      addr_chk = 1'b0; stall_en = 1'b0; stall_seen = 1'b0;
      n_out = 0; busy_cnt = 0; done_cnt = 0; tap = 0; stall_left = 0;
      repeat (3) @(posedge clk);
      #1 check_idle("rst");
      rst = 1'b0;

      for (int i = 0; i < 64; i++) mem[i] = 8'h55;
      run_map("flat", 1'b0, 0);

      for (int i = 0; i < 64; i++) mem[i] = 8'(i);
      addr_chk = 1'b1;
      run_map("ramp", 1'b0, 0);
      chk("ramp_addr_taps", tap, 9);
      addr_chk = 1'b0;

      mem[36] = 8'h00;
      run_map("hole", 1'b1, 0);

      for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3 + 7);
      run_map("stall", 1'b0, 20);

      // reset in the middle of window (3,1)
      for (int i = 0; i < 64; i++) mem[i] = 8'(8'hf0 - i);
      push_expected();
      n_out = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 1000 && n_out < 19; i++) @(posedge clk);
      chk("midrst_reach", n_out, 19);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1 check_idle("midrst");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      run_map("after_rst", 1'b0, 0);

      mem[0] = 8'h80;
      for (int i = 1; i < 64; i++) mem[i] = 8'h01;
      run_map("sign", 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
